// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle add/sub/and/or/slt, bit-serial
// shifts and shift-add multiply driven by an IDLE/BUSY/DONE state machine.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {IT_SLL, IT_SRL, IT_MUL} iter_t;

  state_t           state;
  iter_t            iter;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] quick_result;
  logic             slt_bit;

  assign slt_bit = $signed(src_a_i) < $signed(src_b_i);

  always_comb begin
    quick_result = '0;
    case (alu_control_i)
      3'b000:  quick_result = src_a_i + src_b_i;
      3'b001:  quick_result = src_a_i - src_b_i;
      3'b010:  quick_result = src_a_i & src_b_i;
      3'b011:  quick_result = src_a_i | src_b_i;
      3'b101:  quick_result = {{(WIDTH-1){1'b0}}, slt_bit};
      default: quick_result = '0;
    endcase
  end

  // Shifts reuse acc as the shifting value; mul uses acc as the product sum.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      iter   <= IT_SLL;
      count  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            case (alu_control_i)
              3'b100: begin
                iter  <= IT_SLL;
                acc   <= src_a_i;
                count <= {1'b0, src_b_i[SW-1:0]};
                state <= BUSY;
              end
              3'b110: begin
                iter  <= IT_SRL;
                acc   <= src_a_i;
                count <= {1'b0, src_b_i[SW-1:0]};
                state <= BUSY;
              end
              3'b111: begin
                iter  <= IT_MUL;
                acc   <= '0;
                op_a  <= src_a_i;
                op_b  <= src_b_i;
                count <= CW'(WIDTH);
                state <= BUSY;
              end
              default: begin
                result <= quick_result;
                zero   <= (quick_result == '0);
                state  <= DONE;
              end
            endcase
          end
        end
        BUSY: begin
          if (count != '0) begin
            case (iter)
              IT_SLL: acc <= acc << 1;
              IT_SRL: acc <= acc >> 1;
              default: begin
                if (op_b[0]) acc <= acc + op_a;
                op_a <= op_a << 1;
                op_b <= op_b >> 1;
              end
            endcase
            count <= count - 1'b1;
          end else begin
            result <= acc;
            zero   <= (acc == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state == BUSY);
  assign out_valid_o = (state == DONE);
  assign result_o    = result;
  assign zero_o      = zero;

endmodule
